axis_header_insert: RTL and testbench
=====================================

Name: axis_header_insert

Overview:
- Upstream neighbour of the handshake pipeline register. Merges a per-packet header word with an AXI-Stream data packet and emits one byte-contiguous stream: header bytes first, then data bytes.
- Output is registered with a valid/ready skid-free stage (ready propagates as ~valid_out | ready_out). It feeds the pipeline register directly.

Parameters:
- DATA_WD, 32, data/header width in bits; must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat; also the width of every keep bus.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  data beat valid.
- data_in  in  DATA_WD  data beat; byte lane DATA_BYTE_WD-1 (MSB) is first on the wire.
- keep_in  in  DATA_BYTE_WD  byte enables, left-aligned. Must be all-ones except on the last beat (1111/1110/1100/1000).
- last_in  in  1  last beat of packet.
- ready_in  out  1  data beat accepted when valid_in & ready_in.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header word; valid bytes are right-aligned.
- keep_insert  in  DATA_BYTE_WD  header byte enables, right-aligned contiguous (0001/0011/0111/1111); N = popcount, 1..DATA_BYTE_WD.
- ready_insert  out  1  header accepted when valid_insert & ready_insert.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  merged beat; unused byte lanes driven 0.
- keep_out  out  DATA_BYTE_WD  left-aligned byte enables.
- last_out  out  1  last beat of merged packet.
- ready_out  in  1  downstream ready.

Behaviour:
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0 (combinational from state). State=IDLE, residual register cleared.
- Output register advance condition adv = ~valid_out | ready_out. While valid_out & ~ready_out, all outputs are held stable.
- Residual register res (DATA_WD bits, left-aligned) plus byte count rc.
- IDLE: ready_insert=1, ready_in=0. On header handshake: res <= header valid bytes left-aligned, rc <= N, go STREAM. Data arriving before the header waits; it is never dropped.
- STREAM: ready_insert=0, ready_in=adv. On a data handshake, the output beat is res[rc bytes] followed by the top (DATA_BYTE_WD-rc) bytes of data_in. Then res <= the remaining rc bytes of data_in, left-aligned.
  - Not last: keep_out all-ones, last_out=0.
  - Last beat with M valid bytes and N+M <= DATA_BYTE_WD: keep_out has N+M ones, last_out=1, go IDLE.
  - Last beat with N+M > DATA_BYTE_WD: full beat, last_out=0, rc <= N+M-DATA_BYTE_WD, go TAIL.
- TAIL: ready_in=0, ready_insert=0. When adv: output res, keep_out = rc ones left-aligned, last_out=1, go IDLE.
- When adv is true and no new beat is produced, valid_out <= 0.
- N = DATA_BYTE_WD: the header forms a full first beat and data passes through delayed by one beat, with a TAIL beat. This is legal.
- Latency: first output beat registered 1 cycle after the first data handshake. Throughput 1 beat/cycle within a packet. One bubble between packets (IDLE header cycle).
- Reset mid-packet discards the partial packet; the next packet starts cleanly from IDLE.
- Illegal keep encodings: behaviour undefined. Flag them with simulation-only assertions.

Optional Feature:
- Macro HDR_INSERT_PKT_CNT_EN.
- Defined: adds output pkt_cnt (16 bits). It increments on each valid_out & ready_out & last_out, wraps 0xFFFF->0, and resets to 0.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package hdr_insert_pkg holds:
  - state typedef (IDLE, STREAM, TAIL);
  - constant DATA_BYTE_WD default;
  - functions keep_to_cnt (popcount) and cnt_to_keep_left (count to left-aligned mask).
- Sub-module hdr_byte_merge (combinational) takes res, rc, data_in, keep_in, last_in. It returns merged beat, keep, next residual and next rc. It is unit-testable in isolation.

Test Plan:
- Header 32'h0000AABB keep 0011; data 32'h11223344, 32'h55667788 (keep 1111), 32'h99AA0000 keep 1100 last -> out 32'hAABB1122, 32'h33445566, 32'h778899AA keep 1111 last=1; no TAIL.
- Header 32'h00CCDDEE keep 0111; single data 32'h11223344 keep 1111 last -> out 32'hCCDDEE11 keep 1111 last=0, then 32'h22334400 keep 1110 last=1.
- Header keep 1111 value 32'hDEADBEEF; data 32'h01020304 last keep 1000 -> out 32'hDEADBEEF last=0, then 32'h01000000 keep 1000 last=1.
- Case 1 with ready_out toggled 1,0,0,1 -> each output held unchanged while stalled; ready_in low during stall; byte sequence identical to case 1.
- Data valid before header; reset asserted while in STREAM -> data not accepted before header; after reset valid_out=0, ready_insert=1, next packet output is correct.
- With HDR_INSERT_PKT_CNT_EN: 3 back-to-back packets -> pkt_cnt = 3.

Source files
------------

// File: rtl/hdr_insert_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header inserter.
package hdr_insert_pkg;

    typedef enum logic [1:0] {StIdle, StStream, StTail} state_e;

    localparam int unsigned DefDataByteWd = 4;
    // Helper functions work on a fixed maximum lane count; callers zero-extend or slice.
    localparam int unsigned MaxByteWd = 64;

    function automatic int unsigned keep_to_cnt(input logic [MaxByteWd-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MaxByteWd; i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [MaxByteWd-1:0] cnt_to_keep_left(input int unsigned cnt,
                                                              input int unsigned nbytes);
        logic [MaxByteWd-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MaxByteWd; i++) begin
            if (i < nbytes && i + cnt >= nbytes) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hdr_byte_merge.sv
// Combinational merge of the left-aligned residual bytes with one incoming data beat.
module hdr_byte_merge
    import hdr_insert_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned RC_WD        = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0]      res_i,
    input  logic [RC_WD-1:0]        rc_i,
    input  logic [DATA_WD-1:0]      data_i,
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    input  logic                    last_i,
    output logic [DATA_WD-1:0]      beat_data_o,
    output logic [DATA_BYTE_WD-1:0] beat_keep_o,
    output logic                    beat_last_o,
    output logic                    beat_tail_o,
    output logic [DATA_WD-1:0]      res_next_o,
    output logic [RC_WD-1:0]        rc_next_o
);

    logic [DATA_WD-1:0]   masked;
    logic [MaxByteWd-1:0] keep_x;
    logic [MaxByteWd-1:0] mask_x;
    int unsigned          total;
    logic                 unused_mask;

    assign unused_mask = ^mask_x;

    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            masked[8*i +: 8] = data_i[8*i +: 8] & {8{keep_i[i]}};
        end
        keep_x = '0;
        keep_x[DATA_BYTE_WD-1:0] = keep_i;
        total  = keep_to_cnt(keep_x) + 32'(rc_i);
        mask_x = cnt_to_keep_left(total, DATA_BYTE_WD);

        // Residual bytes occupy the top rc lanes; data fills the lanes below them.
        beat_data_o = res_i | (masked >> (8 * rc_i));
        res_next_o  = masked << (8 * (DATA_BYTE_WD - 32'(rc_i)));
        beat_keep_o = '1;
        beat_last_o = 1'b0;
        beat_tail_o = 1'b0;
        rc_next_o   = rc_i;

        if (last_i) begin
            if (total <= DATA_BYTE_WD) begin
                beat_keep_o = mask_x[DATA_BYTE_WD-1:0];
                beat_last_o = 1'b1;
                rc_next_o   = '0;
                res_next_o  = '0;
            end else begin
                beat_tail_o = 1'b1;
                rc_next_o   = RC_WD'(total - DATA_BYTE_WD);
            end
        end
    end

endmodule

// File: rtl/axis_header_insert.sv
// Prepends a right-aligned header word to an AXI-Stream packet, registered output stage.
// Optional 16-bit packet counter output enabled by defining HDR_INSERT_PKT_CNT_EN.
module axis_header_insert
    import hdr_insert_pkg::*;
#(
    parameter int unsigned DATA_WD      = 8 * DefDataByteWd,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
`ifdef HDR_INSERT_PKT_CNT_EN
    output logic [15:0]             pkt_cnt,
`endif
    input  logic                    ready_out
);

    localparam int unsigned RcW = $clog2(DATA_BYTE_WD + 1);

    state_e                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [RcW-1:0]          rc_q, rc_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;

    logic                    adv;
    logic [MaxByteWd-1:0]    hkeep_x;
    logic [MaxByteWd-1:0]    tail_mask_x;
    int unsigned             n_hdr;
    logic [DATA_WD-1:0]      hdr_left;
    logic                    unused_tail_mask;

    logic [DATA_WD-1:0]      m_data, m_res;
    logic [DATA_BYTE_WD-1:0] m_keep;
    logic                    m_last, m_tail;
    logic [RcW-1:0]          m_rc;

    assign adv          = ~valid_q | ready_out;
    assign ready_insert = ~rst & (state_q == StIdle);
    assign ready_in     = ~rst & (state_q == StStream) & adv;
    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign keep_out     = keep_q;
    assign last_out     = last_q;

    always_comb begin
        hkeep_x = '0;
        hkeep_x[DATA_BYTE_WD-1:0] = keep_insert;
        n_hdr       = keep_to_cnt(hkeep_x);
        hdr_left    = data_insert << (8 * (DATA_BYTE_WD - n_hdr));
        tail_mask_x = cnt_to_keep_left(32'(rc_q), DATA_BYTE_WD);
    end

    assign unused_tail_mask = ^tail_mask_x;

    hdr_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .RC_WD        (RcW)
    ) u_merge (
        .res_i       (res_q),
        .rc_i        (rc_q),
        .data_i      (data_in),
        .keep_i      (keep_in),
        .last_i      (last_in),
        .beat_data_o (m_data),
        .beat_keep_o (m_keep),
        .beat_last_o (m_last),
        .beat_tail_o (m_tail),
        .res_next_o  (m_res),
        .rc_next_o   (m_rc)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rc_d    = rc_q;
        valid_d = adv ? 1'b0 : valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;

        case (state_q)
            StIdle: begin
                if (valid_insert) begin
                    res_d   = hdr_left;
                    rc_d    = RcW'(n_hdr);
                    state_d = StStream;
                end
            end
            StStream: begin
                if (valid_in && adv) begin
                    valid_d = 1'b1;
                    data_d  = m_data;
                    keep_d  = m_keep;
                    last_d  = m_last;
                    res_d   = m_res;
                    rc_d    = m_rc;
                    if (m_last)      state_d = StIdle;
                    else if (m_tail) state_d = StTail;
                end
            end
            StTail: begin
                if (adv) begin
                    valid_d = 1'b1;
                    data_d  = res_q;
                    keep_d  = tail_mask_x[DATA_BYTE_WD-1:0];
                    last_d  = 1'b1;
                    res_d   = '0;
                    rc_d    = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            res_q   <= '0;
            rc_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

`ifdef HDR_INSERT_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (valid_q && ready_out && last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

`ifndef SYNTHESIS
    // Header keep must be right-aligned contiguous; data keep full except a left-aligned last.
    logic hdr_keep_ok, data_keep_ok;
    assign hdr_keep_ok  = (keep_insert != '0) &&
                          ((keep_insert & (keep_insert + 1'b1)) == '0);
    assign data_keep_ok = last_in ? ((keep_in != '0) && (((~keep_in) & ((~keep_in) + 1'b1)) == '0))
                                  : (&keep_in);

    a_hdr_keep: assert property (@(posedge clk) disable iff (rst)
        (valid_insert && ready_insert) |-> hdr_keep_ok)
        else $error("illegal keep_insert %b", keep_insert);
    a_data_keep: assert property (@(posedge clk) disable iff (rst)
        (valid_in && ready_in) |-> data_keep_ok)
        else $error("illegal keep_in %b last %b", keep_in, last_in);
`endif

endmodule

// File: tb/tb_axis_header_insert.sv
// Directed, table-driven bench for axis_header_insert (32-bit, 4 lanes).
module tb_axis_header_insert;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_insert, ready_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
`ifdef HDR_INSERT_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_header_insert #(.DATA_WD(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .ready_insert (ready_insert),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
`ifdef HDR_INSERT_PKT_CNT_EN
        .pkt_cnt      (pkt_cnt),
`endif
        .ready_out    (ready_out)
    );

    typedef struct {
        logic [31:0]      hdr;
        logic [3:0]       hkeep;
        int               nb;
        logic [3:0][31:0] d;
        logic [3:0][3:0]  k;
        int               ne;
        logic [3:0][31:0] ed;
        logic [3:0][3:0]  ek;
        logic [3:0]       el;
    } vec_t;

    vec_t       vecs[5];
    logic [3:0] stall_pat = 4'b1001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input bit early);
        int t;
        if (early) begin
            valid_in = 1'b1; data_in = v.d[0]; keep_in = v.k[0]; last_in = (v.nb == 1);
            repeat (3) begin
                @(negedge clk);
                chk("early_ready_in", ready_in, 0);
                chk("early_valid_out", valid_out, 0);
            end
        end
        valid_insert = 1'b1; data_insert = v.hdr; keep_insert = v.hkeep;
        t = 0;
        @(negedge clk);
        while (!ready_insert && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("hdr_handshake_timeout", 1, 0);
        @(posedge clk); #1;
        valid_insert = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            valid_in = 1'b1; data_in = v.d[b]; keep_in = v.k[b]; last_in = (b == v.nb - 1);
            t = 0;
            @(negedge clk);
            while (!ready_in && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) chk("data_handshake_timeout", 1, 0);
            @(posedge clk); #1;
        end
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic monitor(input vec_t v, input bit stall);
        int          got = 0;
        bit          held = 0;
        logic [31:0] hd;
        logic [3:0]  hk;
        logic        hl;
        for (int c = 0; c < 60 && got < v.ne; c++) begin
            @(posedge clk); #1;
            ready_out = stall ? stall_pat[c % 4] : 1'b1;
            @(negedge clk);
            if (held) begin
                chk("stall_data_held", data_out, hd);
                chk("stall_keep_held", keep_out, hk);
                chk("stall_last_held", last_out, hl);
            end
            if (valid_out && ready_out) begin
                chk($sformatf("beat%0d_data", got), data_out, v.ed[got]);
                chk($sformatf("beat%0d_keep", got), keep_out, v.ek[got]);
                chk($sformatf("beat%0d_last", got), last_out, v.el[got]);
                got++;
            end
            held = valid_out && !ready_out;
            if (held) begin
                chk("stall_ready_in_low", ready_in, 0);
                hd = data_out; hk = keep_out; hl = last_out;
            end
        end
        chk("beat_count", got, v.ne);
    endtask

    task automatic run_pkt(input vec_t v, input bit stall, input bit early);
        @(posedge clk); #1;
        fork
            drive(v, early);
            monitor(v, stall);
        join
        ready_out = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Packed arrays list elements highest index first.
        vecs[0] = '{32'h0000AABB, 4'b0011, 3,
                    {32'h0, 32'h99AA0000, 32'h55667788, 32'h11223344},
                    {4'h0, 4'b1100, 4'b1111, 4'b1111}, 3,
                    {32'h0, 32'h778899AA, 32'h33445566, 32'hAABB1122},
                    {4'h0, 4'b1111, 4'b1111, 4'b1111}, 4'b0100};
        vecs[1] = '{32'h00CCDDEE, 4'b0111, 1,
                    {32'h0, 32'h0, 32'h0, 32'h11223344},
                    {4'h0, 4'h0, 4'h0, 4'b1111}, 2,
                    {32'h0, 32'h0, 32'h22334400, 32'hCCDDEE11},
                    {4'h0, 4'h0, 4'b1110, 4'b1111}, 4'b0010};
        vecs[2] = '{32'hDEADBEEF, 4'b1111, 1,
                    {32'h0, 32'h0, 32'h0, 32'h01020304},
                    {4'h0, 4'h0, 4'h0, 4'b1000}, 2,
                    {32'h0, 32'h0, 32'h01000000, 32'hDEADBEEF},
                    {4'h0, 4'h0, 4'b1000, 4'b1111}, 4'b0010};
        vecs[3] = '{32'h000000A5, 4'b0001, 2,
                    {32'h0, 32'h0, 32'h55667788, 32'h11223344},
                    {4'h0, 4'h0, 4'b1110, 4'b1111}, 2,
                    {32'h0, 32'h0, 32'h44556677, 32'hA5112233},
                    {4'h0, 4'h0, 4'b1111, 4'b1111}, 4'b0010};
        vecs[4] = '{32'h0000AABB, 4'b0011, 1,
                    {32'h0, 32'h0, 32'h0, 32'h12345678},
                    {4'h0, 4'h0, 4'h0, 4'b1000}, 1,
                    {32'h0, 32'h0, 32'h0, 32'hAABB1200},
                    {4'h0, 4'h0, 4'h0, 4'b1110}, 4'b0001};

        rst = 1'b1; ready_out = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_ready_insert", ready_insert, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_insert", ready_insert, 1);
        chk("idle_ready_in", ready_in, 0);

        for (int i = 0; i < 5; i++) run_pkt(vecs[i], 1'b0, 1'b0);
`ifdef HDR_INSERT_PKT_CNT_EN
        @(negedge clk);
        chk("pkt_cnt_after_5", pkt_cnt, 5);
`endif
        run_pkt(vecs[0], 1'b1, 1'b0);
        run_pkt(vecs[1], 1'b0, 1'b1);

        // Reset while streaming: header and one data beat accepted, then reset.
        @(posedge clk); #1;
        valid_insert = 1'b1; data_insert = 32'h0000AABB; keep_insert = 4'b0011;
        @(negedge clk);
        chk("mid_ready_insert", ready_insert, 1);
        @(posedge clk); #1;
        valid_insert = 1'b0;
        valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'b1111; last_in = 1'b0;
        @(negedge clk);
        chk("mid_ready_in", ready_in, 1);
        @(posedge clk); #1;
        data_in = 32'h55667788;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_in", ready_in, 0);
        chk("mid_rst_ready_insert", ready_insert, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_out", valid_out, 0);
        chk("post_rst_ready_insert", ready_insert, 1);
        chk("post_rst_ready_in", ready_in, 0);
        valid_in = 1'b0;
        run_pkt(vecs[0], 1'b0, 1'b0);
`ifdef HDR_INSERT_PKT_CNT_EN
        @(negedge clk);
        chk("pkt_cnt_after_rst", pkt_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
